// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder with request/response valid/ready handshakes and
// programmable wait states. Define DMEM_ERR_EN to flag out-of-range addresses via rsp_err_o.
module dmem_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                oob_q, oob_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                ready_en_q;

  // Store is not reset; zero initial contents exist for simulation only.
  logic [31:0]         mem_q [DEPTH] = '{default: 32'h0};

  logic                accept;
  logic                req_oob;
  logic                access;
  logic                acc_we;
  logic [ADDR_W-1:0]   acc_addr;
  logic [31:0]         acc_wdata;
  logic                acc_oob;
  logic                mem_we;

`ifdef DMEM_ERR_EN
  assign req_oob = (req_addr_i >= 32'(DEPTH));
`else
  logic unused_addr;
  assign unused_addr = ^req_addr_i[31:ADDR_W];
  assign req_oob     = 1'b0;
`endif

  assign req_ready_o = (state_q == StIdle) && ready_en_q;
  assign accept      = req_valid_i && req_ready_o;
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  // With zero wait states the access happens on the accept edge, straight from the inputs.
  always_comb begin
    if (state_q == StIdle) begin
      acc_we    = req_we_i;
      acc_addr  = req_addr_i[ADDR_W-1:0];
      acc_wdata = req_wdata_i;
      acc_oob   = req_oob;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_oob   = oob_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    oob_d   = oob_q;
    access  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i[ADDR_W-1:0];
          wdata_d = req_wdata_i;
          oob_d   = req_oob;
          if (WAIT_CYCLES > 0) begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = StResp;
            access  = 1'b1;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (access) begin
      err_d   = acc_oob;
      rdata_d = (acc_we || acc_oob) ? 32'h0 : mem_q[acc_addr];
    end
  end

  assign mem_we = access && acc_we && !acc_oob;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      oob_q      <= 1'b0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      oob_q      <= oob_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      ready_en_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[acc_addr] <= acc_wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with 0, 3 and 2 wait states.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Index 0: WAIT_CYCLES=0, 1: WAIT_CYCLES=3, 2: WAIT_CYCLES=2
  logic        req_valid [3];
  logic        req_we    [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic        rsp_ready [3];
  logic        req_ready [3];
  logic        rsp_valid [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int checks = 0;
  int errors = 0;

  dmem_responder #(.DEPTH(64), .ADDR_W(6), .WAIT_CYCLES(0)) u_w0 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
    .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
    .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0])
  );

  dmem_responder #(.DEPTH(64), .ADDR_W(6), .WAIT_CYCLES(3)) u_w3 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
    .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
    .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1])
  );

  dmem_responder #(.DEPTH(64), .ADDR_W(6), .WAIT_CYCLES(2)) u_w2 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]), .req_we_i(req_we[2]),
    .req_addr_i(req_addr[2]), .req_wdata_i(req_wdata[2]),
    .rsp_valid_o(rsp_valid[2]), .rsp_ready_i(rsp_ready[2]),
    .rsp_rdata_o(rsp_rdata[2]), .rsp_err_o(rsp_err[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction; inputs are scrambled right after accept, and an optional stall holds
  // rsp_ready low while a competing request is presented.
  task automatic txn(input int s, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input int stall,
                     output logic [31:0] rdata, output logic err, output int lat,
                     output logic rdy_low);
    int n;
    @(negedge clk);
    req_valid[s] = 1'b1;
    req_we[s]    = we;
    req_addr[s]  = addr;
    req_wdata[s] = wdata;
    n = 0;
    while (!req_ready[s] && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_we[s]    = ~we;
    req_addr[s]  = addr ^ 32'h1;
    req_wdata[s] = ~wdata;
    req_valid[s] = (stall > 0);
    lat     = (n < 20) ? 1 : 99;
    rdy_low = 1'b1;
    while (!rsp_valid[s] && lat < 20) begin
      rdy_low &= ~req_ready[s];
      @(negedge clk);
      lat++;
    end
    rdy_low &= ~req_ready[s];
    rdata = rsp_rdata[s];
    err   = rsp_err[s];
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid[s]), 32'd1);
      check("bp_rdata", rsp_rdata[s], rdata);
      check("bp_req_ready", 32'(req_ready[s]), 32'd0);
    end
    req_valid[s] = 1'b0;
    rsp_ready[s] = 1'b1;
    @(negedge clk);
    rsp_ready[s] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        rl;

    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_addr[i]  = 32'h0;
      req_wdata[i] = 32'h0;
      rsp_ready[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_req_ready", 32'(req_ready[i]), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
      check("rst_rsp_rdata", rsp_rdata[i], 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) check("rel_req_ready", 32'(req_ready[i]), 32'd1);

    // Zero wait states: store then load.
    txn(0, 1'b1, 32'd5, 32'hDEAD_BEEF, 0, rd, er, lat, rl);
    check("w0_st_lat", 32'(lat), 32'd1);
    check("w0_st_rdata", rd, 32'h0);
    check("w0_st_err", 32'(er), 32'd0);
    txn(0, 1'b0, 32'd5, 32'h0, 0, rd, er, lat, rl);
    check("w0_ld_lat", 32'(lat), 32'd1);
    check("w0_ld_rdata", rd, 32'hDEAD_BEEF);
    check("w0_ld_err", 32'(er), 32'd0);

    // Three wait states, then backpressure.
    txn(1, 1'b1, 32'd10, 32'h1234_5678, 0, rd, er, lat, rl);
    check("w3_st_lat", 32'(lat), 32'd4);
    txn(1, 1'b0, 32'd10, 32'h0, 0, rd, er, lat, rl);
    check("w3_ld_lat", 32'(lat), 32'd4);
    check("w3_ld_ready_low", 32'(rl), 32'd1);
    check("w3_ld_rdata", rd, 32'h1234_5678);
    txn(1, 1'b0, 32'd10, 32'h0, 5, rd, er, lat, rl);
    check("w3_bp_rdata", rd, 32'h1234_5678);
    check("w3_bp_lat", 32'(lat), 32'd4);

    // Reset during the wait phase of a store.
    txn(2, 1'b1, 32'd8, 32'h1111_2222, 0, rd, er, lat, rl);
    check("w2_st_lat", 32'(lat), 32'd3);
    txn(2, 1'b0, 32'd8, 32'h0, 0, rd, er, lat, rl);
    check("w2_ld8_rdata", rd, 32'h1111_2222);
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b1;
    req_addr[2]  = 32'd7;
    req_wdata[2] = 32'hAAAA_5555;
    @(negedge clk);
    req_valid[2] = 1'b0;
    check("w2_in_wait_ready", 32'(req_ready[2]), 32'd0);
    check("w2_in_wait_valid", 32'(rsp_valid[2]), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid[2]), 32'd0);
    check("mid_rst_rdata", rsp_rdata[2], 32'h0);
    check("mid_rst_ready", 32'(req_ready[2]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready[2]), 32'd1);
    txn(2, 1'b0, 32'd7, 32'h0, 0, rd, er, lat, rl);
    check("w2_ld7_rdata", rd, 32'h0);
    check("w2_ld7_lat", 32'(lat), 32'd3);
    txn(0, 1'b0, 32'd5, 32'h0, 0, rd, er, lat, rl);
    check("w0_ld5_after_rst", rd, 32'hDEAD_BEEF);

    // Address 64: error or wrap depending on configuration.
    txn(0, 1'b1, 32'd64, 32'hCAFE_F00D, 0, rd, er, lat, rl);
    check("a64_st_lat", 32'(lat), 32'd1);
`ifdef DMEM_ERR_EN
    check("a64_st_err", 32'(er), 32'd1);
    txn(0, 1'b0, 32'd0, 32'h0, 0, rd, er, lat, rl);
    check("a64_dm0", rd, 32'h0);
    check("a64_dm0_err", 32'(er), 32'd0);
    txn(0, 1'b0, 32'd64, 32'h0, 0, rd, er, lat, rl);
    check("a64_ld_rdata", rd, 32'h0);
    check("a64_ld_err", 32'(er), 32'd1);
`else
    check("a64_st_err", 32'(er), 32'd0);
    txn(0, 1'b0, 32'd0, 32'h0, 0, rd, er, lat, rl);
    check("a64_dm0", rd, 32'hCAFE_F00D);
    check("a64_dm0_err", 32'(er), 32'd0);
    txn(0, 1'b0, 32'd64, 32'h0, 0, rd, er, lat, rl);
    check("a64_ld_rdata", rd, 32'hCAFE_F00D);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
